// File: rtl/mux_n_1_stream.sv
// N:1 stream multiplexer with valid/ready handshakes, explicit-select or
// round-robin arbitration, and a single registered output stage.
module mux_n_1_stream #(
  parameter int N_CH  = 3,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic [N_CH-1:0]  grant;
  logic             gvalid;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] gdata;
  logic             can_load;
  logic             xfer;
  int unsigned      idx;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  // Select mode matches sel against every index, so out-of-range sel grants nothing.
  always_comb begin
    grant  = '0;
    gvalid = 1'b0;
    gidx   = '0;
    gdata  = '0;
    idx    = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant[i] = 1'b1;
          gvalid   = 1'b1;
          gidx     = SEL_W'(i);
          gdata    = in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!gvalid && in_valid[idx]) begin
          grant[idx] = 1'b1;
          gvalid     = 1'b1;
          gidx       = SEL_W'(idx);
          gdata      = in_data[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign can_load = !out_valid_q || out_ready;
  assign xfer     = gvalid && can_load && rst_n;
  assign in_ready = rst_n ? (grant & {N_CH{can_load}}) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gdata;
      out_ch_d    = gidx;
      if (mode) rr_ptr_d = (gidx == SEL_W'(N_CH-1)) ? '0 : gidx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Scoreboard bench: a negedge reference model predicts grants and pushes
// expected words; a monitor checks the output register against the queue.
module tb_mux_n_1_stream;
  localparam int N_CH  = 3;
  localparam int WIDTH = 8;
  localparam int SEL_W = $clog2(N_CH);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mode = 1'b0;
  logic [SEL_W-1:0]      sel = '0;
  logic [N_CH-1:0]       in_valid = '0;
  logic [N_CH*WIDTH-1:0] in_data = '0;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready = 1'b0;

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] d;
  } word_t;

  word_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mv = 1'b0;
  int rr = 0;

  mux_n_1_stream #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    mv = 1'b0;
    rr = 0;
    q.delete();
  end

  // Reference model: grant rules evaluated directly on the current inputs.
  always @(negedge clk) begin
    int eg;
    int s;
    bit cl;
    logic [N_CH-1:0] er;
    word_t w;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_ch", 32'(out_ch), 0);
    end else begin
      eg = -1;
      s  = int'(sel);
      if (!mode) begin
        if (s < N_CH) if (in_valid[s]) eg = s;
      end else begin
        for (int k = 0; k < N_CH; k++)
          if (eg < 0 && in_valid[(rr + k) % N_CH]) eg = (rr + k) % N_CH;
      end
      cl = !mv || out_ready;
      er = '0;
      if (eg >= 0 && cl) er[eg] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(mv));
      if (eg >= 0 && cl) begin
        w.ch = eg;
        w.d  = in_data[eg*WIDTH +: WIDTH];
        q.push_back(w);
        if (mode) rr = (eg + 1) % N_CH;
      end
      mv = (eg >= 0 && cl) || (mv && !out_ready);
    end
  end

  // Monitor: the held word must always equal the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("out_ch", 32'(out_ch), 32'(q[0].ch));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic m, input logic [SEL_W-1:0] s,
                      input logic [N_CH-1:0] v, input logic r);
    @(posedge clk);
    #1;
    mode = m; sel = s; in_valid = v; out_ready = r;
    in_data = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with all channels valid
    in_valid = 3'b111; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; mode = 1'b0; sel = 2'd1; in_data = {8'hC2, 8'hB1, 8'hA0};
    @(negedge clk); chk("t1_in_ready", 32'(in_ready), 32'b010);
    @(negedge clk); chk("t1_out_data", 32'(out_data), 32'hB1);
    chk("t1_out_ch", 32'(out_ch), 1);

    // out-of-range select
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd3, 3'b111, 1'b1);
      @(negedge clk); chk("t2_in_ready", 32'(in_ready), 0);
    end
    chk("t2_out_valid", 32'(out_valid), 0);

    // round-robin fairness, stops with rr_ptr at 1
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 2'd0, 3'b111, 1'b1);
      @(negedge clk); chk("t3_in_ready", 32'(in_ready), 32'(1 << (i % 3)));
    end

    // skip over an idle channel
    step(1'b1, 2'd0, 3'b101, 1'b1);
    @(negedge clk); chk("t4_grant2", 32'(in_ready), 32'b100);
    step(1'b1, 2'd0, 3'b101, 1'b1);
    @(negedge clk); chk("t4_grant0", 32'(in_ready), 32'b001);

    // backpressure then simultaneous drain and load
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 3'b111, 1'b0);
      @(negedge clk); chk("t5_in_ready", 32'(in_ready), 0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 3'b111, 1'b1);

    // asynchronous reset pulse between edges
    step(1'b1, 2'd0, 3'b110, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1; chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_in_ready", 32'(in_ready), 0);
    #1; rst_n = 1'b1;
    @(negedge clk); chk("t6_first_grant", 32'(in_ready), 32'b010);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom), 2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom_range(0, 3) != 0));

    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 3'b000, 1'b1);
    @(negedge clk); chk("final_queue_empty", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux_n_1_stream.md
Name: mux_n_1_stream

Overview:
- Parametrised N:1 data-path multiplexer with valid/ready handshakes on every input channel and on the output.
- Next generation of the team's combinational 3:1 select muxes, with configurable channel count and data width.
- Two modes: explicit select, where software or the FSM drives `sel`, and round-robin arbitration.
- Registered output (one pipeline stage); sits between multiple producers and one consumer.

Parameters:
- N_CH, 3, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- SEL_W, $clog2(N_CH), width of `sel` and `out_ch`.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = select mode, 1 = round-robin mode.
- sel  input  SEL_W  channel index used in select mode.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_CH  per-channel ready (combinational).
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer rr_ptr=0.
  - in_ready is all-zero while reset is asserted.
- Output stage:
  - can_load = !out_valid | out_ready.
  - At most one input transfer per cycle.
  - Latency from input handshake to out_valid is 1 cycle.
  - Full throughput is 1 transfer/cycle when out_ready is held high.
- Grant, combinational, one-hot or zero:
  - Select mode: grant[sel]=in_valid[sel]. If sel >= N_CH, grant=0, no channel is served and nothing is lost.
  - Round-robin mode: grant goes to the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_CH. If no valid, grant=0.
- in_ready[i] = grant[i] & can_load.
  - Non-granted channels see ready=0 even if valid.
  - in_ready never depends on in_valid of the same channel beyond the grant computation.
- Transfer occurs when grant[g] & can_load. On the next edge:
  - out_data=in_data[g], out_ch=g, out_valid=1.
  - In round-robin mode only: rr_ptr = (g+1) mod N_CH.
- Output drain: out_valid & out_ready & no new transfer means out_valid goes to 0 next edge. out_data and out_ch hold their last values.
- Output backpressure: out_valid & !out_ready means out_data and out_ch are held stable, and all in_ready are 0.
- rr_ptr behaviour:
  - Updates only on round-robin transfers.
  - Holds in select mode and in idle cycles.
  - Wraps from N_CH-1 to 0.
- Mode or sel changes:
  - Take effect in the same cycle's grant.
  - A word already in the output register is unaffected.
  - rr_ptr is retained across mode switches.
- Simultaneous drain and load in the same cycle: the new word replaces the old one with no bubble, and out_valid stays 1.
- Reset mid-transfer: the pending output word is discarded and rr_ptr returns to 0.
- Upstream must hold in_data stable while in_valid=1 and not accepted. The block does not check this.

Test Plan:
1. Reset and select mode:
   - Stimulus: assert rst_n=0 with in_valid=3'b111 and out_ready=1 -> out_valid=0, out_data=0, in_ready=0. Then release reset with mode=0, sel=1, in_data={8'hC2,8'hB1,8'hA0}.
   - Required response: in_ready=3'b010, and one cycle later out_data=8'hB1, out_ch=1.
2. Invalid select:
   - Stimulus: mode=0, sel=3 (N_CH=3), all valid.
   - Required response: in_ready=0 and out_valid stays 0 for 5 cycles.
3. Round-robin fairness:
   - Stimulus: mode=1, all three channels valid continuously, out_ready=1.
   - Required response: out_ch sequence 0,1,2,0,1,2, with out_valid=1 every cycle after the first.
4. Round-robin skip:
   - Stimulus: mode=1, only in_valid[2] and in_valid[0] set, rr_ptr=1.
   - Required response: grant goes to channel 2 first, then 0; rr_ptr becomes 0, then 1.
5. Backpressure:
   - Stimulus: out_ready=0 for 4 cycles with data pending.
   - Required response: out_data and out_ch remain frozen and in_ready=0. On out_ready=1, drain and load occur in the same cycle with no lost or duplicated word (scoreboard check).
6. Asynchronous reset mid-stream:
   - Stimulus: pulse rst_n low between clock edges during round-robin traffic.
   - Required response: out_valid drops immediately, and after release the first grant goes to the lowest valid channel starting from 0.
